// File: rtl/decoder_pkg.sv
// Shared decoder-side definitions: select width, channel count and scan state encoding.
package decoder_pkg;
    localparam int SEL_W  = 3;
    localparam int NUM_CH = 8;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_t;
endpackage

// File: rtl/decoder_scan_seq_if.sv
// Control/status bundle of the decoder select sequencer; the skip mask exists only with SCAN_SKIP_EN.
// Handshake: start is a level sampled only while idle; stop aborts at the next edge; step/done are one-cycle pulses.
interface decoder_scan_seq_if
    import decoder_pkg::*;
#(
    parameter int DWELL_W = 8
);
    logic               start;
    logic               stop;
    logic               mode;
    logic [DWELL_W-1:0] dwell;
    logic [SEL_W-1:0]   last;
`ifdef SCAN_SKIP_EN
    logic [NUM_CH-1:0]  skip;
`endif
    logic [SEL_W-1:0]   sel;
    logic               active;
    logic               step;
    logic               done;
    scan_state_t        state;

    modport master (
`ifdef SCAN_SKIP_EN
        output skip,
`endif
        output start, stop, mode, dwell, last,
        input  sel, active, step, done, state
    );

    modport slave (
`ifdef SCAN_SKIP_EN
        input  skip,
`endif
        input  start, stop, mode, dwell, last,
        output sel, active, step, done, state
    );
endinterface

// File: rtl/decoder_scan_next.sv
// Channel search: first, next (wrapping) and last enabled channel among 0..last not masked by skip.
module decoder_scan_next
    import decoder_pkg::*;
(
    input  logic [SEL_W-1:0]  cur,
    input  logic [SEL_W-1:0]  last,
    input  logic [NUM_CH-1:0] skip,
    output logic [SEL_W-1:0]  first,
    output logic [SEL_W-1:0]  next,
    output logic              is_last,
    output logic              none_valid
);
    logic [NUM_CH-1:0] valid;
    logic [SEL_W-1:0]  last_ch;
    logic              found;

    always_comb begin
        valid   = '0;
        first   = '0;
        next    = '0;
        last_ch = '0;
        found   = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            valid[i] = (i <= int'(last)) && !skip[i];
        end
        // Descending scans leave the lowest hit; ascending leaves the highest.
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (valid[i]) first = SEL_W'(i);
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (valid[i]) last_ch = SEL_W'(i);
        end
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (valid[i] && (i > int'(cur))) begin
                next  = SEL_W'(i);
                found = 1'b1;
            end
        end
        if (!found) next = first;
    end

    assign is_last    = (cur == last_ch);
    assign none_valid = ~|valid;
endmodule

// File: rtl/decoder_scan_seq.sv
// Select sequencer feeding the 3-to-8 decoder: steps sel through channels with a programmable dwell.
// Optional channel skip mask enabled by SCAN_SKIP_EN.
module decoder_scan_seq
    import decoder_pkg::*;
#(
    parameter int DWELL_W = 8
) (
    input logic                clk,
    input logic                rst,
    decoder_scan_seq_if.slave  bus
);
    scan_state_t        state;
    logic [SEL_W-1:0]   sel;
    logic [SEL_W-1:0]   last_q;
    logic [SEL_W-1:0]   last_in;
    logic [SEL_W-1:0]   first_ch;
    logic [SEL_W-1:0]   next_ch;
    logic [DWELL_W-1:0] cnt;
    logic [DWELL_W-1:0] dwell_q;
    logic               mode_q;
    logic               active;
    logic               step;
    logic               done;
    logic               is_last;
    logic               none_valid;
    logic [NUM_CH-1:0]  skip_in;

    // While idle the search looks at the live inputs so the first channel is ready at start.
`ifdef SCAN_SKIP_EN
    logic [NUM_CH-1:0]  skip_q;
    assign skip_in = (state == IDLE) ? bus.skip : skip_q;
`else
    assign skip_in = '0;
`endif
    assign last_in = (state == IDLE) ? bus.last : last_q;

    decoder_scan_next u_next (
        .cur        (sel),
        .last       (last_in),
        .skip       (skip_in),
        .first      (first_ch),
        .next       (next_ch),
        .is_last    (is_last),
        .none_valid (none_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            sel     <= '0;
            active  <= 1'b0;
            step    <= 1'b0;
            done    <= 1'b0;
            cnt     <= '0;
            dwell_q <= '0;
            last_q  <= '0;
            mode_q  <= 1'b0;
`ifdef SCAN_SKIP_EN
            skip_q  <= '0;
`endif
        end else begin
            step <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start && !bus.stop && !none_valid) begin
                        mode_q  <= bus.mode;
                        dwell_q <= bus.dwell;
                        last_q  <= bus.last;
`ifdef SCAN_SKIP_EN
                        skip_q  <= bus.skip;
`endif
                        sel     <= first_ch;
                        cnt     <= bus.dwell;
                        active  <= 1'b1;
                        step    <= 1'b1;
                        state   <= SCAN;
                    end
                end
                SCAN: begin
                    if (bus.stop) begin
                        active <= 1'b0;
                        state  <= IDLE;
                    end else if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (!is_last) begin
                        sel  <= next_ch;
                        cnt  <= dwell_q;
                        step <= 1'b1;
                    end else if (!mode_q) begin
                        sel  <= first_ch;
                        cnt  <= dwell_q;
                        step <= 1'b1;
                    end else begin
                        active <= 1'b0;
                        done   <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.sel    = sel;
    assign bus.active = active;
    assign bus.step   = step;
    assign bus.done   = done;
    assign bus.state  = state;
endmodule

// File: tb/tb_decoder_scan_seq.sv
// Scoreboard bench for decoder_scan_seq: the model predicts every step/done pulse with its edge number.
module tb_decoder_scan_seq;
    import decoder_pkg::*;

    localparam int W = 20;  // {edge[15:0], done, sel[2:0]}

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;
    logic [W-1:0] exp_q[$];

    decoder_scan_seq_if #(.DWELL_W(8)) bus();

    decoder_scan_seq #(.DWELL_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    function automatic logic [W-1:0] pack(input int t, input int d, input int s);
        return {t[15:0], d[0], s[2:0]};
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin : monitor
        logic [W-1:0] got;
        if (!rst && (bus.step || bus.done)) begin
            got = {cyc[15:0], bus.done, bus.sel};
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_event: got %0h want none", got);
            end else begin
                check("event", got, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver + reference model ----------------
    task automatic run_scan(input logic m, input logic [7:0] d, input logic [2:0] l,
                            input logic [7:0] sk, input int run_len, input bit poke);
        int list[$];
        int n, period, m_edge, t, k, b;
        int last_sel;
        for (int i = 0; i <= int'(l); i++) if (!sk[i]) list.push_back(i);
        period = int'(d) + 1;
        last_sel = 0;
        @(negedge clk);
        bus.mode  = m;
        bus.dwell = d;
        bus.last  = l;
`ifdef SCAN_SKIP_EN
        bus.skip  = sk;
`endif
        bus.start = 1'b1;
        n = cyc + 1;
        if (list.size() == 0) begin
            @(negedge clk);
            bus.start = 1'b0;
            repeat (5) @(negedge clk);
            check("empty_idle", bus.active, 0);
            return;
        end
        if (m) begin
            for (int j = 0; j < list.size(); j++) exp_q.push_back(pack(n + j * period, 0, list[j]));
            exp_q.push_back(pack(n + list.size() * period, 1, list[list.size() - 1]));
        end else begin
            m_edge = n + run_len;
            k = 0;
            t = n;
            while (t < m_edge) begin
                last_sel = list[k % list.size()];
                exp_q.push_back(pack(t, 0, last_sel));
                k++;
                t += period;
            end
        end
        @(negedge clk);
        bus.start = 1'b0;
        check("active_on", bus.active, 1);
        if (poke && (!m || list.size() * period > 3)) begin
            @(negedge clk);
            bus.start = 1'b1;
            bus.dwell = d + 8'd3;
            bus.last  = l ^ 3'd5;
            bus.mode  = ~m;
            @(negedge clk);
            bus.start = 1'b0;
        end
        if (!m) begin
            while (cyc < m_edge - 1) @(negedge clk);
            bus.stop = 1'b1;
            @(negedge clk);
            bus.stop = 1'b0;
            check("stop_active", bus.active, 0);
            check("stop_sel", bus.sel, last_sel);
        end else begin
            b = 0;
            while (bus.active && b < 5000) begin
                @(negedge clk);
                b++;
            end
            check("sweep_in_budget", b < 5000, 1);
            check("done_sel", bus.sel, list[list.size() - 1]);
        end
        repeat (2) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.mode  = 1'b0;
        bus.dwell = '0;
        bus.last  = '0;
`ifdef SCAN_SKIP_EN
        bus.skip  = '0;
`endif
        repeat (3) @(negedge clk);
        check("rst_sel", bus.sel, 0);
        check("rst_active", bus.active, 0);
        check("rst_step", bus.step, 0);
        check("rst_done", bus.done, 0);
        check("rst_state", bus.state, IDLE);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_scan(1'b1, 8'd2, 3'd7, 8'h00, 0, 1'b0);
        run_scan(1'b0, 8'd0, 3'd2, 8'h00, 20, 1'b0);
        run_scan(1'b0, 8'd3, 3'd0, 8'h00, 17, 1'b0);
        run_scan(1'b1, 8'd0, 3'd0, 8'h00, 0, 1'b0);

        // start and stop together: stop wins
        @(negedge clk);
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        bus.mode  = 1'b1;
        bus.dwell = 8'd1;
        bus.last  = 3'd3;
        @(negedge clk);
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        check("start_stop_active", bus.active, 0);
        repeat (4) @(negedge clk);
        check("start_stop_state", bus.state, IDLE);

        run_scan(1'b1, 8'd4, 3'd5, 8'h00, 0, 1'b1);
        run_scan(1'b0, 8'd1, 3'd6, 8'h00, 23, 1'b1);

`ifdef SCAN_SKIP_EN
        run_scan(1'b1, 8'd0, 3'd6, 8'h25, 0, 1'b0);
        run_scan(1'b1, 8'd1, 3'd6, 8'h7F, 0, 1'b0);
        run_scan(1'b0, 8'd1, 3'd7, 8'h5A, 25, 1'b0);
`endif

        for (int r = 0; r < 12; r++) begin
            logic [7:0] sk;
            sk = '0;
`ifdef SCAN_SKIP_EN
            sk = 8'($urandom_range(0, 255));
`endif
            run_scan(1'($urandom_range(0, 1)), 8'($urandom_range(0, 4)), 3'($urandom_range(0, 7)),
                     sk, $urandom_range(5, 40), 1'($urandom_range(0, 1)));
        end

        // reset in the middle of a sweep
        @(negedge clk);
        bus.mode  = 1'b1;
        bus.dwell = 8'd3;
        bus.last  = 3'd7;
`ifdef SCAN_SKIP_EN
        bus.skip  = '0;
`endif
        bus.start = 1'b1;
        n = cyc + 1;
        for (int j = 0; j < 8; j++) exp_q.push_back(pack(n + 4 * j, 0, j));
        exp_q.push_back(pack(n + 32, 1, 7));
        @(negedge clk);
        bus.start = 1'b0;
        repeat (6) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_sel", bus.sel, 0);
        check("midrst_active", bus.active, 0);
        check("midrst_step", bus.step, 0);
        check("midrst_done", bus.done, 0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("post_rst_active", bus.active, 0);
        check("post_rst_sel", bus.sel, 0);

        run_scan(1'b1, 8'd1, 3'd3, 8'h00, 0, 1'b0);

        check("final_queue", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/decoder_scan_seq.md
# decoder_scan_seq

Upstream select sequencer for the 3-to-8 decoder. It steps a 3-bit select through channels 0..last, holding each channel for a programmable dwell time. Continuous and single-sweep modes are supported. The decoder consumes `sel` directly, and downstream logic qualifies the decoder outputs with `active`.

## Interface
- `DWELL_W`, default 8: width of the dwell count.
- `clk` input 1: clock, rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `start` input 1: begin a scan; sampled only in IDLE.
- `stop` input 1: abort the scan; highest priority.
- `mode` input 1: 0 = continuous wrap, 1 = single sweep; latched at start.
- `dwell` input DWELL_W: channel hold time is dwell+1 cycles; latched at start.
- `last` input 3: highest channel in the sweep; latched at start.
- `skip` input 8: channel mask, 1 = skip; present only with `SCAN_SKIP_EN`; latched at start.
- `sel` output 3: select to the decoder (I2 = sel[2], I1 = sel[1], I0 = sel[0]).
- `active` output 1: high while a scan is running.
- `step` output 1: one-cycle pulse in the first cycle of each newly presented channel.
- `done` output 1: one-cycle pulse when a single sweep completes.

## Operation
- Reset values:
  - `sel` = 0, `active` = 0, `step` = 0, `done` = 0.
  - Dwell counter = 0, state = IDLE.
- States are IDLE and SCAN.
- IDLE:
  - `start` = 1 and `stop` = 0: latch `mode`, `dwell`, `last` (and `skip`).
  - Set `sel` = first channel, load counter = latched dwell, set `active` = 1, pulse `step`.
  - Move to SCAN.
- SCAN, each cycle:
  - If `stop` = 1: go to IDLE with `active` = 0. No `done` pulse. `sel` holds.
  - Else if counter ≠ 0: decrement the counter.
  - Else, at dwell expiry:
    - If `sel` ≠ last channel: `sel` = next channel, reload counter, pulse `step`.
    - If `sel` = last channel and mode 0: `sel` = first channel, reload counter, pulse `step`.
    - If `sel` = last channel and mode 1: go to IDLE, `active` = 0, pulse `done`. `sel` holds.
- Boundary rules:
  - `start` while in SCAN is ignored.
  - `start` and `stop` in the same IDLE cycle: stop wins, and the block stays in IDLE.
  - `last` = 0: channel 0 only. In mode 0, `step` pulses every dwell+1 cycles and `sel` stays 0.
  - `dwell` = 0: `sel` advances every cycle, and `step` stays high during the sweep.
  - Input changes during SCAN have no effect until the next start.
- Reset mid-scan immediately forces the reset values. No `done` pulse is produced.

## Timing
- `start` sampled high at edge N: `sel`, `active` and `step` are valid after edge N.
- Channel k of the sweep (k = 0, 1, …) is presented from edge N + k·(dwell+1).
- `done` is asserted in the cycle after edge N + (L+1)·(dwell+1), where L+1 is the number of presented channels. `active` falls at the same edge.
- `stop` sampled at edge M: `active` = 0 after edge M.
- A new `start` is accepted at edge M+1 at the earliest.
- All outputs are registered. There is no combinational path from any input to any output.

## Configuration
- Macro: `SCAN_SKIP_EN`.
- Defined:
  - The `skip` port exists.
  - The first channel and each next channel are the lowest unmasked channel ≤ last, searched above the current channel and then wrapping.
  - "Last channel" means the highest unmasked channel ≤ last.
  - If every channel 0..last is masked, `start` is ignored and the block stays in IDLE with no pulses.
- Undefined:
  - There is no `skip` port.
  - The first channel is 0, the next channel is `sel`+1, and the last channel is `last`.

## Structure
- Package `decoder_pkg`:
  - `SEL_W` = 3, `NUM_CH` = 8.
  - A state enum (IDLE, SCAN) shared with other decoder-side blocks.
- Sub-module `decoder_scan_next`:
  - Combinational.
  - Inputs: current `sel`, `last`, `skip`.
  - Outputs: first channel, next channel, is_last flag, none_valid flag.
  - Instantiated in both configurations, with `skip` tied to 0 when `SCAN_SKIP_EN` is undefined.

## Test plan
- Reset mid-sweep:
  - Stimulus: assert `rst` during a sweep.
  - Response: all outputs go to 0 immediately, and after release no activity occurs until `start`.
- Basic single sweep:
  - Stimulus: `mode` = 1, `dwell` = 2, `last` = 7, `start` at edge 10.
  - Response: `sel` = 0..7, each held 3 cycles; 8 `step` pulses; `done` after edge 34; `active` falls at edge 34.
- Continuous wrap:
  - Stimulus: `mode` = 0, `dwell` = 0, `last` = 2.
  - Response: `sel` runs 0,1,2,0,1,2… every cycle; `step` stays high; `stop` drops `active` next edge with no `done`.
- Priority and ignored inputs:
  - `start` and `stop` in the same cycle: the block stays in IDLE.
  - `start` during SCAN: ignored.
  - Changing `dwell` mid-scan: hold time stays at the latched value.
- Skip mask (`SCAN_SKIP_EN`):
  - `skip` = 8'b0010_0101, `last` = 6, mode 1: `sel` runs 1,3,4,6, then `done`.
  - `skip` = 8'h7F, `last` = 6: `start` is ignored.
